// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers and known maximal-length tap masks.
package lfsr_pkg;

  // Widest state the helpers handle; callers zero-extend narrower states.
  localparam int unsigned LfsrMaxWidth = 32;

  localparam logic [3:0]  TAPS_4  = 4'b0011;
  localparam logic [7:0]  TAPS_8  = 8'b00011101;
  localparam logic [15:0] TAPS_16 = 16'h002D;

  // Feedback bit: parity of the tapped state bits.
  function automatic logic lfsr_fb(input logic [LfsrMaxWidth-1:0] state,
                                   input logic [LfsrMaxWidth-1:0] taps);
    return ^(state & taps);
  endfunction

  // One Fibonacci step: shift right, feedback enters at bit width-1.
  function automatic logic [LfsrMaxWidth-1:0] lfsr_next(input logic [LfsrMaxWidth-1:0] state,
                                                        input logic [LfsrMaxWidth-1:0] taps,
                                                        input int unsigned width);
    logic [LfsrMaxWidth-1:0] fb_ext;
    fb_ext = LfsrMaxWidth'(lfsr_fb(state, taps));
    return (state >> 1) | (fb_ext << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_clamp.sv
// Combinational saturation of a value into [MIN_VAL, MAX_VAL].
module lfsr_clamp #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  MIN_VAL = WIDTH'(2),
  parameter logic [WIDTH-1:0]  MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  // Clamp below to MIN_VAL and above to MAX_VAL, otherwise pass through.
  always_comb begin
    val_o = val_i;
    if (val_i < MIN_VAL) begin
      val_o = MIN_VAL;
    end else if (val_i > MAX_VAL) begin
      val_o = MAX_VAL;
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lock-up recovery, wrap detection
// and a clamped value output.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(TAPS_4),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
  parameter logic [WIDTH-1:0] MIN_VAL = WIDTH'(2),
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o,
  output logic             rnd_o,
  output logic [WIDTH-1:0] val_o,
  output logic             wrap_o,
  output logic             lockup_o,
  output logic [WIDTH-1:0] steps_o
);

  if (WIDTH < 2 || WIDTH > LfsrMaxWidth) begin : g_width_chk
    $error("lfsr_gen: WIDTH must lie in 2..32");
  end
  if (SEED == '0) begin : g_seed_chk
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (MIN_VAL > MAX_VAL) begin : g_clamp_chk
    $error("lfsr_gen: MIN_VAL must not exceed MAX_VAL");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] state_nxt;

  assign state_nxt = WIDTH'(lfsr_next(LfsrMaxWidth'(state_q), LfsrMaxWidth'(TAPS), WIDTH));

  // Next-state: load beats en beats hold; pulses default low.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    steps_d  = steps_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      steps_d = '0;
      if (seed_i != '0) begin
        state_d = seed_i;
        start_d = seed_i;
      end else begin
        // A zero seed would lock the register; fall back to SEED.
        state_d  = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
    end else if (en) begin
      state_d = state_nxt;
      if (state_nxt == start_q) begin
        wrap_d  = 1'b1;
        steps_d = '0;
      end else begin
        steps_d = steps_q + WIDTH'(1);
      end
    end
  end

  // State, start point, step counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEED;
      start_q  <= SEED;
      steps_q  <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      steps_q  <= steps_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  lfsr_clamp #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_clamp (
    .val_i(state_q),
    .val_o(val_o)
  );

  assign state_o  = state_q;
  assign rnd_o    = lfsr_fb(LfsrMaxWidth'(state_q), LfsrMaxWidth'(TAPS));
  assign wrap_o   = wrap_q;
  assign lockup_o = lockup_q;
  assign steps_o  = steps_q;

endmodule
